fir_tap_frontend: RTL and testbench

- Upstream stage of the 4-tap dynamic FIR multiply-accumulate core.
- Accepts a byte stream on one port. Each byte is tagged as a sample, a coefficient or a control op.
- Maintains the 4-deep sample delay line and drives it on x0..x3.
- Keeps a shadow coefficient bank. Once a full set of four is loaded, it commits atomically to h0..h3, so the core never sees a half-updated filter.

---
 rtl/fir_tap_frontend.sv | 137 +++++++++++++
 tb/tb_fir_tap_frontend.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_frontend.sv
// ============================================================================
// Module   : fir_tap_frontend
// Brief    : Byte-stream front end for the 4-tap FIR core. It maintains the
//            sample delay line and a shadow coefficient bank with atomic commit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_tap_frontend #(
    parameter int                       DW     = 8,
    parameter logic signed [DW-1:0]     H0_RST = 8'sd1,
    parameter logic signed [DW-1:0]     H1_RST = 8'sd0,
    parameter logic signed [DW-1:0]     H2_RST = 8'sd0,
    parameter logic signed [DW-1:0]     H3_RST = 8'sd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                in_valid,
    input  logic [1:0]          in_op,
    input  logic signed [DW-1:0] in_data,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3,
    output logic signed [DW-1:0] h0,
    output logic signed [DW-1:0] h1,
    output logic signed [DW-1:0] h2,
    output logic signed [DW-1:0] h3,
    output logic                x_valid,
    output logic                primed,
    output logic [1:0]          coef_idx,
    output logic                coef_commit
);

    localparam logic [1:0] c_op_sample = 2'b00;
    localparam logic [1:0] c_op_coef   = 2'b01;
    localparam logic [1:0] c_op_flush  = 2'b10;
    localparam logic [1:0] c_op_abort  = 2'b11;

    // The encoding is the next shadow slot, so ST_IDLE is the only non-loading
    // state. LOAD1 to LOAD3 together form the LOADING state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD1 = 2'd1,
        ST_LOAD2 = 2'd2,
        ST_LOAD3 = 2'd3
    } coef_state_t;

    coef_state_t                r_state;
    logic signed [DW-1:0]       r_shadow [0:2];
    logic [2:0]                 r_cnt;
    logic                       w_accept;

    assign w_accept = ena & in_valid;
    assign coef_idx = r_state;

    // Slot 3 is never stored. The last byte goes straight into h3 on the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0          <= '0;
            x1          <= '0;
            x2          <= '0;
            x3          <= '0;
            h0          <= H0_RST;
            h1          <= H1_RST;
            h2          <= H2_RST;
            h3          <= H3_RST;
            r_shadow[0] <= '0;
            r_shadow[1] <= '0;
            r_shadow[2] <= '0;
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            primed      <= 1'b0;
            x_valid     <= 1'b0;
            coef_commit <= 1'b0;
        end else begin
            x_valid     <= 1'b0;
            coef_commit <= 1'b0;
            if (w_accept) begin
                case (in_op)
                    c_op_sample: begin
                        x3      <= x2;
                        x2      <= x1;
                        x1      <= x0;
                        x0      <= in_data;
                        x_valid <= 1'b1;
                        if (r_cnt != 3'd4) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                        primed  <= (r_cnt >= 3'd3);
                    end
                    c_op_coef: begin
                        case (r_state)
                            ST_IDLE: begin
                                r_shadow[0] <= in_data;
                                r_state     <= ST_LOAD1;
                            end
                            ST_LOAD1: begin
                                r_shadow[1] <= in_data;
                                r_state     <= ST_LOAD2;
                            end
                            ST_LOAD2: begin
                                r_shadow[2] <= in_data;
                                r_state     <= ST_LOAD3;
                            end
                            ST_LOAD3: begin
                                h0          <= r_shadow[0];
                                h1          <= r_shadow[1];
                                h2          <= r_shadow[2];
                                h3          <= in_data;
                                coef_commit <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                    c_op_flush: begin
                        x0     <= '0;
                        x1     <= '0;
                        x2     <= '0;
                        x3     <= '0;
                        r_cnt  <= 3'd0;
                        primed <= 1'b0;
                    end
                    c_op_abort: begin
                        r_state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_frontend.sv
// ============================================================================
// Module   : tb_fir_tap_frontend
// Brief    : Directed vector table, async-reset corner and randomized
//            model-checked stimulus for fir_tap_frontend.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_tap_frontend;

    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena = 1'b0;
    logic                 in_valid = 1'b0;
    logic [1:0]           in_op = 2'b00;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] x0, x1, x2, x3, h0, h1, h2, h3;
    logic                 x_valid, primed, coef_commit;
    logic [1:0]           coef_idx;

    int checks = 0;
    int failures = 0;

    fir_tap_frontend #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
        .in_op(in_op), .in_data(in_data),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3),
        .x_valid(x_valid), .primed(primed),
        .coef_idx(coef_idx), .coef_commit(coef_commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        v;
        logic [1:0]  op;
        logic [7:0]  d;
        logic [31:0] ex;   // {x0,x1,x2,x3}
        logic [31:0] eh;   // {h0,h1,h2,h3}
        logic [4:0]  ef;   // {x_valid, primed, coef_idx, coef_commit}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic v, input logic [1:0] op,
                                input logic [7:0] d, input logic [31:0] ex,
                                input logic [31:0] eh, input logic xv, input logic pr,
                                input logic [1:0] idx, input logic cm);
        vec_t r;
        r.en = en; r.v = v; r.op = op; r.d = d;
        r.ex = ex; r.eh = eh; r.ef = {xv, pr, idx, cm};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [1:0] op, input logic [7:0] d);
        ena = en; in_valid = v; in_op = op; in_data = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a history queue holds the samples, newest first, and a
    // pending queue holds the partial coefficient set.
    logic [7:0] mq[$];
    logic [7:0] mpend[$];
    logic [7:0] mh[4];
    int         msince;
    logic       mxv, mcm;

    task automatic model_reset();
        mq.delete(); mpend.delete();
        mh[0] = 8'd1; mh[1] = 8'd0; mh[2] = 8'd0; mh[3] = 8'd0;
        msince = 0; mxv = 1'b0; mcm = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic v, input logic [1:0] op, input logic [7:0] d);
        mxv = 1'b0; mcm = 1'b0;
        if (en && v) begin
            case (op)
                2'b00: begin
                    mq.push_front(d);
                    if (mq.size() > 4) void'(mq.pop_back());
                    msince++;
                    mxv = 1'b1;
                end
                2'b01: begin
                    mpend.push_back(d);
                    if (mpend.size() == 4) begin
                        for (int i = 0; i < 4; i++) mh[i] = mpend[i];
                        mpend.delete();
                        mcm = 1'b1;
                    end
                end
                2'b10: begin
                    mq.delete();
                    msince = 0;
                end
                default: mpend.delete();
            endcase
        end
    endtask

    function automatic logic [7:0] mx(input int i);
        return (i < mq.size()) ? mq[i] : 8'd0;
    endfunction

    initial begin
        logic [1:0] rop;
        logic       ren, rv;
        logic [7:0] rd;
        int         r;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", {x0, x1, x2, x3}, 32'h0);
        chk("reset_h", {h0, h1, h2, h3}, 32'h01000000);
        chk("reset_flags", {x_valid, primed, coef_idx, coef_commit}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: en, v, op, data, {x0..x3}, {h0..h3}, xv, primed, idx, commit
        tbl.push_back(mk(1,1,2'b00, 8'd5,    {8'd5,  8'd0,  8'd0,  8'd0},  {8'd1,8'd0,8'd0,8'd0}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, -8'sd3,  {-8'sd3,8'd5,  8'd0,  8'd0},  {8'd1,8'd0,8'd0,8'd0}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd7,    {8'd7,  -8'sd3,8'd5,  8'd0},  {8'd1,8'd0,8'd0,8'd0}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd2,    {8'd2,  8'd7,  -8'sd3,8'd5},  {8'd1,8'd0,8'd0,8'd0}, 1,1,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd9,    {8'd9,  8'd2,  8'd7,  -8'sd3},{8'd1,8'd0,8'd0,8'd0}, 1,1,2'd0,0));
        tbl.push_back(mk(1,1,2'b01, 8'd10,   {8'd9,  8'd2,  8'd7,  -8'sd3},{8'd1,8'd0,8'd0,8'd0}, 0,1,2'd1,0));
        tbl.push_back(mk(1,1,2'b00, 8'd4,    {8'd4,  8'd9,  8'd2,  8'd7},  {8'd1,8'd0,8'd0,8'd0}, 1,1,2'd1,0));
        tbl.push_back(mk(1,1,2'b01, 8'd20,   {8'd4,  8'd9,  8'd2,  8'd7},  {8'd1,8'd0,8'd0,8'd0}, 0,1,2'd2,0));
        tbl.push_back(mk(1,1,2'b01, -8'sd30, {8'd4,  8'd9,  8'd2,  8'd7},  {8'd1,8'd0,8'd0,8'd0}, 0,1,2'd3,0));
        tbl.push_back(mk(1,1,2'b00, 8'd6,    {8'd6,  8'd4,  8'd9,  8'd2},  {8'd1,8'd0,8'd0,8'd0}, 1,1,2'd3,0));
        tbl.push_back(mk(1,1,2'b01, 8'd40,   {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd0,1));
        tbl.push_back(mk(1,0,2'b01, 8'd55,   {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd0,0));
        tbl.push_back(mk(1,1,2'b01, 8'd11,   {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd1,0));
        tbl.push_back(mk(1,1,2'b01, 8'd22,   {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd2,0));
        tbl.push_back(mk(1,1,2'b11, 8'd77,   {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd0,0));
        tbl.push_back(mk(1,1,2'b01, 8'd1,    {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd1,0));
        tbl.push_back(mk(1,1,2'b01, 8'd2,    {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd2,0));
        tbl.push_back(mk(1,1,2'b01, 8'd3,    {8'd6,  8'd4,  8'd9,  8'd2},  {8'd10,8'd20,-8'sd30,8'd40}, 0,1,2'd3,0));
        tbl.push_back(mk(1,1,2'b01, 8'd4,    {8'd6,  8'd4,  8'd9,  8'd2},  {8'd1,8'd2,8'd3,8'd4}, 0,1,2'd0,1));
        tbl.push_back(mk(1,1,2'b10, 8'd99,   {8'd0,  8'd0,  8'd0,  8'd0},  {8'd1,8'd2,8'd3,8'd4}, 0,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd1,    {8'd1,  8'd0,  8'd0,  8'd0},  {8'd1,8'd2,8'd3,8'd4}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd2,    {8'd2,  8'd1,  8'd0,  8'd0},  {8'd1,8'd2,8'd3,8'd4}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd3,    {8'd3,  8'd2,  8'd1,  8'd0},  {8'd1,8'd2,8'd3,8'd4}, 1,0,2'd0,0));
        tbl.push_back(mk(1,1,2'b00, 8'd4,    {8'd4,  8'd3,  8'd2,  8'd1},  {8'd1,8'd2,8'd3,8'd4}, 1,1,2'd0,0));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0,1,2'(k % 2), 8'd99, {8'd4,8'd3,8'd2,8'd1}, {8'd1,8'd2,8'd3,8'd4}, 0,1,2'd0,0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].v, tbl[i].op, tbl[i].d);
            chk($sformatf("vec%0d_x", i), {x0, x1, x2, x3}, tbl[i].ex);
            chk($sformatf("vec%0d_h", i), {h0, h1, h2, h3}, tbl[i].eh);
            chk($sformatf("vec%0d_flags", i), {x_valid, primed, coef_idx, coef_commit}, tbl[i].ef);
        end

        // Asynchronous reset in the middle of a coefficient load
        drive(1, 1, 2'b01, 8'd7);
        drive(1, 1, 2'b01, 8'd8);
        chk("midload_idx", coef_idx, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_x", {x0, x1, x2, x3}, 32'h0);
        chk("async_reset_h", {h0, h1, h2, h3}, 32'h01000000);
        chk("async_reset_flags", {x_valid, primed, coef_idx, coef_commit}, 5'b0);
        ena = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized stimulus against the queue-based reference model
        for (int n = 0; n < 1500; n++) begin
            r    = $urandom_range(0, 99);
            rop  = (r < 45) ? 2'b00 : (r < 85) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
            ren  = ($urandom_range(0, 9) != 0);
            rv   = ($urandom_range(0, 4) != 0);
            rd   = 8'($urandom_range(0, 255));
            drive(ren, rv, rop, rd);
            model_step(ren, rv, rop, rd);
            chk($sformatf("rnd%0d_x", n), {x0, x1, x2, x3}, {mx(0), mx(1), mx(2), mx(3)});
            chk($sformatf("rnd%0d_h", n), {h0, h1, h2, h3}, {mh[0], mh[1], mh[2], mh[3]});
            chk($sformatf("rnd%0d_flags", n), {x_valid, primed, coef_idx, coef_commit},
                {mxv, (msince >= 4), 2'(mpend.size()), mcm});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
